// File: rtl/lfsr_prbs_lock_check.sv
// Self-synchronising PRBS checker: per-bit error mask, HUNT/LOCKED lock tracking
// and saturating error/word statistics gathered while locked.
module lfsr_prbs_lock_check #(
  parameter int unsigned           LFSR_WIDTH   = 31,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY    = 31'h10000001,
  parameter logic [LFSR_WIDTH-1:0] LFSR_INIT    = '1,
  parameter string                 LFSR_CONFIG  = "FIBONACCI",
  parameter bit                    REVERSE      = 1'b0,
  parameter bit                    INVERT       = 1'b1,
  parameter int unsigned           DATA_WIDTH   = 8,
  parameter string                 STYLE        = "AUTO",
  parameter int unsigned           LOCK_COUNT   = 16,
  parameter int unsigned           UNLOCK_COUNT = 4,
  parameter int unsigned           COUNT_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_WIDTH-1:0]  data_in,
  input  logic                   data_in_valid,
  input  logic                   clear_counts,
  output logic [DATA_WIDTH-1:0]  data_out,
  output logic                   data_out_valid,
  output logic                   locked,
  output logic [COUNT_WIDTH-1:0] err_count,
  output logic [COUNT_WIDTH-1:0] word_count
);

  localparam int unsigned POP_W    = $clog2(DATA_WIDTH + 1);
  localparam bit          GALOIS   = (LFSR_CONFIG == "GALOIS");
  localparam logic [15:0] LOCK_N   = 16'(LOCK_COUNT);
  localparam logic [15:0] UNLOCK_N = 16'(UNLOCK_COUNT);

  typedef enum logic {HUNT, LOCKED} lock_state_t;

  // One received bit through the checker: returns {error_bit, next_state}.
  // The Galois form is the transposed FIR of the Fibonacci predictor.
  function automatic logic [LFSR_WIDTH:0] lfsr_step(input logic [LFSR_WIDTH-1:0] st,
                                                    input logic b);
    logic [LFSR_WIDTH-1:0] nxt;
    logic                  pred;
    if (GALOIS) begin
      pred = st[LFSR_WIDTH-1];
      nxt  = (st << 1) ^ ({LFSR_WIDTH{b}} & LFSR_POLY);
    end else begin
      pred = ^(st & LFSR_POLY);
      nxt  = {b, st[LFSR_WIDTH-1:1]};
    end
    return {b ^ pred, nxt};
  endfunction

  logic [LFSR_WIDTH-1:0]  lfsr_state;
  logic [LFSR_WIDTH-1:0]  lfsr_next;
  logic [DATA_WIDTH-1:0]  din_ord;
  logic [DATA_WIDTH-1:0]  err_bits;
  logic [DATA_WIDTH-1:0]  mask;
  logic [POP_W-1:0]       pop;
  logic [COUNT_WIDTH:0]   err_sum;
  logic [15:0]            run_count;
  logic [15:0]            run_inc;
  lock_state_t            state;

  always_comb begin
    din_ord = '0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      din_ord[i] = (REVERSE ? data_in[DATA_WIDTH-1-i] : data_in[i]) ^ INVERT;
    end
  end

  // Mask bits are returned in data_in bit order regardless of REVERSE.
  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      mask[i] = REVERSE ? err_bits[DATA_WIDTH-1-i] : err_bits[i];
    end
  end

  if (STYLE == "REDUCTION") begin : g_unrolled
    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_bit
      logic [LFSR_WIDTH-1:0] st_in;
      logic [LFSR_WIDTH-1:0] st_out;
      if (i == 0) begin : g_head
        assign st_in = lfsr_state;
      end else begin : g_link
        assign st_in = g_bit[i-1].st_out;
      end
      assign {err_bits[DATA_WIDTH-1-i], st_out} = lfsr_step(st_in, din_ord[DATA_WIDTH-1-i]);
    end
    assign lfsr_next = g_bit[DATA_WIDTH-1].st_out;
  end else begin : g_loop
    logic [LFSR_WIDTH-1:0] st;
    always_comb begin
      st       = lfsr_state;
      err_bits = '0;
      for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
        {err_bits[DATA_WIDTH-1-i], st} = lfsr_step(st, din_ord[DATA_WIDTH-1-i]);
      end
      lfsr_next = st;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_state     <= LFSR_INIT;
      data_out       <= '0;
      data_out_valid <= 1'b0;
    end else begin
      data_out_valid <= data_in_valid;
      if (data_in_valid) begin
        lfsr_state <= lfsr_next;
        data_out   <= mask;
      end
    end
  end

  always_comb begin
    pop = '0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      pop = pop + POP_W'(data_out[i]);
    end
  end

  assign err_sum = {1'b0, err_count} + (COUNT_WIDTH+1)'(pop);
  assign run_inc = run_count + 16'd1;

  // Lock FSM and statistics act on the registered mask, one cycle behind data_out.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= HUNT;
      locked     <= 1'b0;
      run_count  <= '0;
      err_count  <= '0;
      word_count <= '0;
    end else begin
      if (data_out_valid) begin
        if (state == LOCKED) begin
          if (word_count != '1) word_count <= word_count + COUNT_WIDTH'(1);
          err_count <= err_sum[COUNT_WIDTH] ? '1 : err_sum[COUNT_WIDTH-1:0];
        end
        case (state)
          HUNT: begin
            if (pop != '0) begin
              run_count <= '0;
            end else if (run_inc == LOCK_N) begin
              state     <= LOCKED;
              locked    <= 1'b1;
              run_count <= '0;
            end else begin
              run_count <= run_inc;
            end
          end
          LOCKED: begin
            if (pop == '0) begin
              run_count <= '0;
            end else if (run_inc == UNLOCK_N) begin
              state     <= HUNT;
              locked    <= 1'b0;
              run_count <= '0;
            end else begin
              run_count <= run_inc;
            end
          end
          default: begin
            state  <= HUNT;
            locked <= 1'b0;
          end
        endcase
      end
      if (clear_counts) begin
        err_count  <= '0;
        word_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_lfsr_prbs_lock_check.sv
// Scoreboard bench: random PRBS31 / corrupted / idle traffic against a bit-history
// reference model; a second instance with 4-bit counters exercises saturation.
module tb_lfsr_prbs_lock_check;

  localparam logic [30:0] POLY     = 31'h10000001;
  localparam int          LOCK_N   = 16;
  localparam int          UNLOCK_N = 4;
  localparam longint      MAX32    = 64'd4294967295;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_in = '0;
  logic       data_in_valid = 1'b0;
  logic       clear_counts = 1'b0;

  logic [7:0]  dout_a, dout_b;
  logic        dov_a, dov_b, lk_a, lk_b;
  logic [31:0] err_a, wc_a;
  logic [3:0]  err_b, wc_b;

  always #5 clk = ~clk;

  lfsr_prbs_lock_check u_dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(data_in_valid),
    .clear_counts(clear_counts), .data_out(dout_a), .data_out_valid(dov_a),
    .locked(lk_a), .err_count(err_a), .word_count(wc_a)
  );

  lfsr_prbs_lock_check #(.COUNT_WIDTH(4)) u_dut_sat (
    .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(data_in_valid),
    .clear_counts(clear_counts), .data_out(dout_b), .data_out_valid(dov_b),
    .locked(lk_b), .err_count(err_b), .word_count(wc_b)
  );

  typedef struct {
    bit     lk;
    longint e32;
    longint w32;
    int     e4;
    int     w4;
  } stat_t;

  logic [7:0] mask_q[$];
  stat_t      stat_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: received (post-inversion) bit history, lock run length, counters.
  bit     rx_hist[31];
  bit     tx_hist[31];
  bit     m_lk;
  int     m_run;
  longint m_e32, m_w32;
  int     m_e4, m_w4;
  bit     m_pend;
  int     m_pend_pc;

  function automatic void model_reset();
    for (int i = 0; i < 31; i++) rx_hist[i] = 1'b1;
    m_lk = 0; m_run = 0; m_pend = 0; m_pend_pc = 0;
    m_e32 = 0; m_w32 = 0; m_e4 = 0; m_w4 = 0;
  endfunction

  // Bit s[m] of a PRBS obeys s[m] = XOR of POLY-selected s[m-31+i]; anything else is an error.
  function automatic logic [7:0] rx_mask(input logic [7:0] d);
    logic [7:0] m;
    bit s, pred;
    for (int j = 7; j >= 0; j--) begin
      s = ~d[j];
      pred = 0;
      for (int i = 0; i < 31; i++) if (POLY[i]) pred ^= rx_hist[i];
      m[j] = s ^ pred;
      for (int i = 0; i < 30; i++) rx_hist[i] = rx_hist[i+1];
      rx_hist[30] = s;
    end
    return m;
  endfunction

  function automatic logic [7:0] prbs_word();
    logic [7:0] w;
    bit nb;
    for (int j = 7; j >= 0; j--) begin
      nb = 0;
      for (int i = 0; i < 31; i++) if (POLY[i]) nb ^= tx_hist[i];
      for (int i = 0; i < 30; i++) tx_hist[i] = tx_hist[i+1];
      tx_hist[30] = nb;
      w[j] = ~nb;
    end
    return w;
  endfunction

  function automatic logic [7:0] flip();
    logic [7:0] one;
    one = 8'h01;
    return one << $urandom_range(0, 7);
  endfunction

  task automatic model_clear();
    m_e32 = 0; m_w32 = 0; m_e4 = 0; m_w4 = 0;
  endtask

  task automatic step(input bit r, input bit v, input logic [7:0] d, input bit c);
    stat_t s;
    bit    errored;
    @(posedge clk);
    #1;
    rst = r; data_in_valid = v; data_in = d; clear_counts = c;
    if (r) begin
      if (m_pend) begin
        s.lk = 0; s.e32 = 0; s.w32 = 0; s.e4 = 0; s.w4 = 0;
        stat_q.push_back(s);
      end
      model_reset();
    end else begin
      if (m_pend) begin
        if (m_lk) begin
          m_w32 = (m_w32 < MAX32) ? m_w32 + 1 : MAX32;
          m_e32 = (m_e32 + m_pend_pc > MAX32) ? MAX32 : m_e32 + m_pend_pc;
          m_w4  = (m_w4 < 15) ? m_w4 + 1 : 15;
          m_e4  = (m_e4 + m_pend_pc > 15) ? 15 : m_e4 + m_pend_pc;
        end
        errored = (m_pend_pc != 0);
        // A word that argues for the other state extends the run; otherwise the run restarts.
        if (errored == m_lk) m_run++;
        else m_run = 0;
        if (m_run == (m_lk ? UNLOCK_N : LOCK_N)) begin
          m_lk  = !m_lk;
          m_run = 0;
        end
        if (c) model_clear();
        s.lk = m_lk; s.e32 = m_e32; s.w32 = m_w32; s.e4 = m_e4; s.w4 = m_w4;
        stat_q.push_back(s);
      end else if (c) begin
        model_clear();
      end
      if (v) begin
        logic [7:0] m;
        m = rx_mask(d);
        mask_q.push_back(m);
        m_pend = 1;
        m_pend_pc = $countones(m);
      end else begin
        m_pend = 0;
      end
    end
  endtask

  // Monitor
  bit         rst_seen = 0;
  bit         stat_pend = 0;
  logic [7:0] last_mask = '0;

  always @(posedge clk) rst_seen <= rst;

  always @(negedge clk) begin
    stat_t      s;
    logic [7:0] em;
    if (rst_seen) begin
      check("rst_dout", {dout_a, dout_b}, 16'h0);
      check("rst_valid", {dov_a, dov_b}, 2'b00);
      check("rst_locked", {lk_a, lk_b}, 2'b00);
      check("rst_counts", {err_a, wc_a, err_b, wc_b}, 72'h0);
      last_mask = '0;
    end
    if (stat_pend) begin
      stat_pend = 0;
      if (stat_q.size() == 0) begin
        check("stat_queue_nonempty", 64'd0, 64'd1);
      end else begin
        s = stat_q.pop_front();
        check("locked", lk_a, s.lk);
        check("locked_sat", lk_b, s.lk);
        check("err_count", err_a, s.e32);
        check("word_count", wc_a, s.w32);
        check("err_count_sat", err_b, s.e4);
        check("word_count_sat", wc_b, s.w4);
      end
    end
    if (dov_a === 1'b1) begin
      if (mask_q.size() == 0) begin
        check("unexpected_valid", 64'd1, 64'd0);
      end else begin
        em = mask_q.pop_front();
        check("mask", dout_a, em);
        check("mask_sat", dout_b, em);
        check("valid_sat", dov_b, 1'b1);
        last_mask = em;
        stat_pend = 1;
      end
    end else if (!rst_seen) begin
      check("mask_hold", {dout_a, dout_b}, {last_mask, last_mask});
      check("valid_low", {dov_a, dov_b}, 2'b00);
    end
  end

  initial begin
    int lat;
    int unsigned r;
    bit c;
    for (int i = 0; i < 31; i++) tx_hist[i] = 1'($urandom_range(0, 1));
    tx_hist[0] = 1'b1;
    model_reset();

    step(1, 1, 8'($urandom), 0);
    step(1, 1, 8'($urandom), 0);

    // Acquisition from reset
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      step(0, 1, prbs_word(), 0);
      if (lat == 0 && lk_a === 1'b1) lat = n;
    end
    check("lock_latency_within_22", (lat != 0 && lat <= 22), 1'b1);

    // Gapped valid
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) != 0) step(0, 1, prbs_word(), 0);
      else step(0, 0, 8'($urandom), 0);
    end

    // Single-bit injections (drives the 4-bit err_count into saturation)
    for (int k = 0; k < 8; k++) begin
      step(0, 1, prbs_word() ^ flip(), 0);
      repeat (10) step(0, 1, prbs_word(), 0);
    end

    // Clear coincident with a counted errored word, then a clear with nothing pending
    step(0, 1, prbs_word() ^ flip(), 0);
    step(0, 1, prbs_word(), 1);
    repeat (5) step(0, 1, prbs_word(), 0);
    step(0, 0, 8'($urandom), 1);
    repeat (5) step(0, 1, prbs_word(), 0);

    // Random data breaks lock, then reacquire
    repeat (12) step(0, 1, 8'($urandom), 0);
    repeat (40) step(0, 1, prbs_word(), 0);

    // Reset mid-lock with in-flight word
    step(1, 1, prbs_word(), 0);
    repeat (40) step(0, 1, prbs_word(), 0);

    // Mixed random traffic
    for (int n = 0; n < 2000; n++) begin
      r = $urandom_range(0, 99);
      c = ($urandom_range(0, 99) < 3);
      if (r < 2)       step(1, 1, 8'($urandom), c);
      else if (r < 5)  step(0, 1, 8'($urandom), c);
      else if (r < 9)  step(0, 1, prbs_word() ^ flip(), c);
      else if (r < 25) step(0, 0, 8'($urandom), c);
      else             step(0, 1, prbs_word(), c);
    end

    repeat (3) step(0, 0, 8'h00, 0);
    @(posedge clk);
    @(negedge clk);
    #1;
    check("mask_queue_drained", mask_q.size(), 0);
    check("stat_queue_drained", stat_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lfsr_prbs_lock_check.md
LFSR_PRBS_LOCK_CHECK -- requirements
Module: lfsr_prbs_lock_check

Interface
REQ-001 Parameter LFSR_WIDTH, 31, LFSR state width.
REQ-002 Parameter LFSR_POLY, 31'h10000001, feedback polynomial, x^n term omitted.
REQ-003 Parameter LFSR_INIT, all ones, LFSR state after reset.
REQ-004 Parameter LFSR_CONFIG, "FIBONACCI", "FIBONACCI" or "GALOIS".
REQ-005 Parameter REVERSE, 0, 1 = bit-reverse data word (LSB first on line).
REQ-006 Parameter INVERT, 1, 1 = input inverted before checking.
REQ-007 Parameter DATA_WIDTH, 8, bits per word.
REQ-008 Parameter STYLE, "AUTO", LFSR implementation style passed to lfsr.
REQ-009 Parameter LOCK_COUNT, 16, consecutive clean words needed to lock, range 1..65535.
REQ-010 Parameter UNLOCK_COUNT, 4, consecutive errored words needed to drop lock, range 1..65535.
REQ-011 Parameter COUNT_WIDTH, 32, width of the statistics counters.
REQ-012 Port clk, input, 1, sole clock; all logic is rising-edge.
REQ-013 Port rst, input, 1, synchronous, active-high reset.
REQ-014 Port data_in, input, DATA_WIDTH, received word.
REQ-015 Port data_in_valid, input, 1, data_in is valid this cycle.
REQ-016 Port clear_counts, input, 1, single-cycle pulse that zeroes both statistics counters.
REQ-017 Port data_out, output, DATA_WIDTH, per-bit error mask (1 = bit error).
REQ-018 Port data_out_valid, output, 1, data_out is valid.
REQ-019 Port locked, output, 1, lock state.
REQ-020 Port err_count, output, COUNT_WIDTH, bit errors accumulated while locked.
REQ-021 Port word_count, output, COUNT_WIDTH, words checked while locked.

Function
REQ-022 The checker SHALL be self-synchronising: each valid input word (after optional inversion/reversal) is shifted into the LFSR. The error mask is the input XOR the LFSR-predicted word.
REQ-023 The LFSR state SHALL advance only on cycles where data_in_valid=1.
REQ-024 data_out and data_out_valid SHALL register one cycle after the input; data_out holds its last value while data_out_valid=0.
REQ-025 A word is "clean" if its mask is zero and "errored" otherwise; the mask popcount is computed at width clog2(DATA_WIDTH+1).
REQ-026 The lock FSM SHALL have two states, HUNT and LOCKED, and SHALL update on the cycle after data_out_valid=1 (two cycles after the input).
REQ-027 In HUNT, a clean word increments run_count and an errored word zeroes it; when run_count reaches LOCK_COUNT, the FSM enters LOCKED and zeroes run_count.
REQ-028 In LOCKED, an errored word increments run_count and a clean word zeroes it; when run_count reaches UNLOCK_COUNT, the FSM enters HUNT and zeroes run_count.
REQ-029 locked SHALL be 1 exactly when the FSM is in LOCKED.
REQ-030 Counters SHALL update only for words evaluated while already LOCKED; the word that causes the transition into LOCKED is not counted, and the word that causes the transition out of LOCKED is counted.
REQ-031 For a counted word, word_count increments by 1 and err_count increments by the popcount; both SHALL saturate at all ones and never wrap.
REQ-032 clear_counts SHALL zero both counters on the next edge and take priority over a simultaneous increment, whose contribution is discarded; the lock state is unaffected.
REQ-033 data_in_valid=0 cycles SHALL affect neither run_count, the counters nor the FSM.

Reset
REQ-034 When rst=1, the LFSR SHALL load LFSR_INIT; data_out=0, data_out_valid=0, FSM=HUNT, run_count=0, locked=0, err_count=0 and word_count=0, all on the next edge.
REQ-035 A reset asserted mid-lock or mid-count SHALL discard all in-flight words; the first input accepted is the one on the cycle after rst deasserts.

Verification
REQ-036 Continuous PRBS31 (inverted, 8-bit) with valid held high: the first 4 masks may be nonzero, then all masks are zero; locked rises no later than cycle 4+16+2; word_count increments once per cycle thereafter; err_count stays 0.
REQ-037 Once locked, flip one bit in one word: err_count increases by exactly 3 (error plus its two tap echoes); locked stays 1.
REQ-038 Once locked, feed 4 words of random data: locked falls 2 cycles after the fourth errored word; counters freeze at the final value including that word.
REQ-039 COUNT_WIDTH=4, locked, and 8 single-bit injections: err_count saturates at 15 and does not wrap.
REQ-040 Assert clear_counts on the same cycle as a counted errored word: both counters read 0 the next cycle, and locked is unchanged.
REQ-041 Assert rst for 1 cycle while locked with nonzero counts: all outputs are 0 the next cycle, and lock is reacquired per REQ-036.
